tetris_sched: RTL
=================

TETRIS_SCHED -- requirements
Module: tetris_sched

Interface
REQ-001 Parameter TICK_BASE, default 50_000_000, gravity period in clk cycles at level 0.
REQ-002 Parameter TICK_STEP, default 4_000_000, period reduction per level.
REQ-003 Parameter TICK_MIN, default 5_000_000, floor on gravity period.
REQ-004 Parameter FIFO_DEPTH, default 4, pending-command queue depth (power of two).
REQ-005 Port list SHALL be:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- btn_req  input  7  one-cycle request pulses, bit0 LEFT, 1 RIGHT, 2 DOWN, 3 DROP, 4 HOLD, 5 ROTATE, 6 ROTATE_REV
- start  input  1  one-cycle pulse, (re)start game
- ready  input  1  engine idle and accepting a command
- score  input  16  engine score, 4-digit BCD
- ctrl  output  control_type  command to engine, registered
- level  output  4  current level 0..9
- busy  output  1  FSM not in IDLE
- fifo_count  output  3  queued commands
- dropped  output  8  saturating count of discarded requests
REQ-006 One clock; reset is asynchronous and active-high.

Function
REQ-007 Encoder SHALL accept at most one btn_req bit per cycle, priority DROP > HOLD > ROTATE > ROTATE_REV > LEFT > RIGHT > DOWN; each other set bit SHALL increment dropped by 1 (all in the same cycle).
REQ-008 Accepted request SHALL be pushed into the FIFO; when full (fifo_count == FIFO_DEPTH, pop not occurring in that cycle) it SHALL be discarded and dropped incremented; simultaneous push and pop on full FIFO SHALL succeed.
REQ-009 dropped SHALL saturate at 255.
REQ-010 level SHALL be 9 when score[15:12] != 0, else min(score[11:8], 9).
REQ-011 Gravity counter SHALL count 0..P-1, P = max(TICK_BASE - level*TICK_STEP, TICK_MIN); P re-evaluated only at wrap; at wrap SHALL set grav_pending (non-stacking single bit).
REQ-012 FSM states: IDLE, BUSY, SETTLE, START.
REQ-013 IDLE, ready==1: grav_pending SHALL take priority -> ctrl=DOWN next cycle, clear grav_pending; else FIFO non-empty -> pop, ctrl=popped command next cycle; either -> BUSY.
REQ-014 ctrl SHALL be a non-NOEVENT value for exactly one cycle per issue, NOEVENT otherwise; BAR SHALL never be issued outside START.
REQ-015 BUSY: ready==0 sampled -> SETTLE; ready held 1 for 4 cycles after issue -> IDLE (command lost, no retry).
REQ-016 SETTLE: ready==1 sampled -> IDLE.
REQ-017 start pulse in any state SHALL take priority over all events: flush FIFO, clear grav_pending and gravity counter, enter START.
REQ-018 START SHALL drive ctrl in a period-3 pattern BAR, NOEVENT, NOEVENT, BAR, ...; exit to IDLE (ctrl NOEVENT) when ready==1 is sampled in a cycle where ctrl was NOEVENT; max 8 BAR pulses, then IDLE.
REQ-019 Gravity counter SHALL be held at 0 in START; btn_req SHALL be ignored (not counted) in START.
REQ-020 busy SHALL equal (state != IDLE); fifo_count SHALL reflect occupancy after each edge.

Reset
REQ-021 On reset: state IDLE, ctrl NOEVENT, FIFO empty, fifo_count 0, dropped 0, grav_pending 0, gravity counter 0, busy 0; level follows score combinationally.
REQ-022 Reset assertion mid-issue or mid-START SHALL abandon the operation with no further ctrl pulse; no automatic start after reset.

Verification (TICK_BASE=20, TICK_STEP=4, TICK_MIN=8, FIFO_DEPTH=4)
REQ-023 ready=1, btn_req=0b0001001 at cycle n -> ctrl=DROP at n+2, dropped=1, LEFT never issued.
REQ-024 ready=0, 6 single LEFT pulses -> fifo_count=4, dropped=2; ready=1 -> four LEFT pulses, each after ready low->high.
REQ-025 score=0x0300, no buttons, ready model returns high 3 cycles after each pulse -> DOWN pulses 8 cycles apart; score=0x0000 -> 20 apart.
REQ-026 grav_pending and queued RIGHT with ready=1 -> DOWN issued first, RIGHT after settle.
REQ-027 start with engine model in END (needs two BARs) -> ctrl BAR, N, N, BAR, then ready=1 -> IDLE, ctrl NOEVENT, exactly 2 BARs.
REQ-028 reset asserted one cycle after an issue -> ctrl NOEVENT, busy=0, fifo_count=0 immediately.

Source files
------------

// File: rtl/tetris_sched.sv
// Command scheduler for a falling-block game engine: encodes button requests, queues them,
// injects gravity ticks and runs the start-of-game BAR handshake.
package tetris_sched_pkg;
  typedef enum logic [3:0] {
    NOEVENT    = 4'd0,
    LEFT       = 4'd1,
    RIGHT      = 4'd2,
    DOWN       = 4'd3,
    DROP       = 4'd4,
    HOLD       = 4'd5,
    ROTATE     = 4'd6,
    ROTATE_REV = 4'd7,
    BAR        = 4'd8
  } control_type;
endpackage

module tetris_sched
  import tetris_sched_pkg::*;
#(
  parameter int unsigned TICK_BASE  = 50_000_000,
  parameter int unsigned TICK_STEP  = 4_000_000,
  parameter int unsigned TICK_MIN   = 5_000_000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  btn_req,
  input  logic        start,
  input  logic        ready,
  input  logic [15:0] score,
  output control_type ctrl,
  output logic [3:0]  level,
  output logic        busy,
  output logic [2:0]  fifo_count,
  output logic [7:0]  dropped
);

  localparam int unsigned AW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [2:0]  DEPTH3 = 3'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_BUSY   = 2'd1;
  localparam logic [1:0] S_SETTLE = 2'd2;
  localparam logic [1:0] S_START  = 2'd3;

  // state is kept as a plain named register so checkers can bind to it directly
  logic [1:0]  state;
  logic [1:0]  busy_cnt;
  logic [1:0]  phase;
  logic [3:0]  bar_cnt;
  logic [31:0] grav_cnt;
  logic [31:0] period;
  logic [31:0] period_next;
  logic [31:0] step_total;
  logic        grav_pending;
  logic        grav_wrap;

  control_type enc_cmd;
  logic        enc_valid;
  logic [2:0]  btn_ones;
  logic        btn_live;
  logic        accept;
  logic        fifo_full;
  logic        fifo_empty;
  logic        issue_grav;
  logic        pop;
  logic        push;
  logic        lost;
  logic [3:0]  drop_inc;
  logic [8:0]  drop_sum;

  control_type      mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // the two low BCD digits never influence the level
  logic unused_score;
  assign unused_score = ^score[7:0];

  always_comb begin
    enc_cmd = NOEVENT;
    if      (btn_req[3]) enc_cmd = DROP;
    else if (btn_req[4]) enc_cmd = HOLD;
    else if (btn_req[5]) enc_cmd = ROTATE;
    else if (btn_req[6]) enc_cmd = ROTATE_REV;
    else if (btn_req[0]) enc_cmd = LEFT;
    else if (btn_req[1]) enc_cmd = RIGHT;
    else if (btn_req[2]) enc_cmd = DOWN;
  end

  always_comb begin
    btn_ones = 3'd0;
    for (int i = 0; i < 7; i++) begin
      btn_ones = btn_ones + 3'(btn_req[i]);
    end
  end

  always_comb begin
    if (score[15:12] != 4'd0)     level = 4'd9;
    else if (score[11:8] > 4'd9)  level = 4'd9;
    else                          level = score[11:8];
  end

  always_comb begin
    step_total = 32'(level) * TICK_STEP;
    if ((step_total >= TICK_BASE) || ((TICK_BASE - step_total) < TICK_MIN)) begin
      period_next = TICK_MIN;
    end else begin
      period_next = TICK_BASE - step_total;
    end
  end

  assign enc_valid  = |btn_req;
  assign btn_live   = (state != S_START) && !start;
  assign accept     = btn_live && enc_valid;
  assign fifo_full  = (fifo_count == DEPTH3);
  assign fifo_empty = (fifo_count == 3'd0);
  // gravity always wins over queued commands when the engine is idle
  assign issue_grav = !start && (state == S_IDLE) && ready && grav_pending;
  assign pop        = !start && (state == S_IDLE) && ready && !grav_pending && !fifo_empty;
  assign push       = accept && (!fifo_full || pop);
  assign lost       = accept && fifo_full && !pop;
  assign drop_inc   = accept ? ({1'b0, btn_ones} - 4'd1 + {3'b000, lost}) : 4'd0;
  assign drop_sum   = {1'b0, dropped} + {5'b00000, drop_inc};
  assign grav_wrap  = (state != S_START) && (grav_cnt >= (period - 32'd1));
  assign busy       = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= enc_cmd;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= 3'd0;
    end else if (start) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= 3'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      fifo_count <= fifo_count + 3'(push) - 3'(pop);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dropped <= 8'd0;
    end else if (accept) begin
      dropped <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      ctrl         <= NOEVENT;
      busy_cnt     <= 2'd0;
      phase        <= 2'd0;
      bar_cnt      <= 4'd0;
      grav_cnt     <= 32'd0;
      period       <= TICK_BASE;
      grav_pending <= 1'b0;
    end else begin
      ctrl <= NOEVENT;
      if (start) begin
        // the first BAR goes out in the same cycle START is entered
        state        <= S_START;
        ctrl         <= BAR;
        phase        <= 2'd0;
        bar_cnt      <= 4'd1;
        grav_cnt     <= 32'd0;
        period       <= period_next;
        grav_pending <= 1'b0;
      end else begin
        if (state == S_START) begin
          grav_cnt <= 32'd0;
        end else if (grav_wrap) begin
          grav_cnt <= 32'd0;
          period   <= period_next;
        end else begin
          grav_cnt <= grav_cnt + 32'd1;
        end

        if (grav_wrap)       grav_pending <= 1'b1;
        else if (issue_grav) grav_pending <= 1'b0;

        case (state)
          S_IDLE: begin
            if (issue_grav) begin
              ctrl     <= DOWN;
              state    <= S_BUSY;
              busy_cnt <= 2'd0;
            end else if (pop) begin
              ctrl     <= mem[rd_ptr];
              state    <= S_BUSY;
              busy_cnt <= 2'd0;
            end
          end
          S_BUSY: begin
            // an engine that never drops ready has ignored the command; give up after 4 cycles
            if (!ready)                 state <= S_SETTLE;
            else if (busy_cnt == 2'd3)  state <= S_IDLE;
            else                        busy_cnt <= busy_cnt + 2'd1;
          end
          S_SETTLE: begin
            if (ready) state <= S_IDLE;
          end
          default: begin
            if ((ctrl == NOEVENT) && ready) begin
              state <= S_IDLE;
            end else if (phase == 2'd2) begin
              phase <= 2'd0;
              if (bar_cnt == 4'd8) begin
                state <= S_IDLE;
              end else begin
                ctrl    <= BAR;
                bar_cnt <= bar_cnt + 4'd1;
              end
            end else begin
              phase <= phase + 2'd1;
            end
          end
        endcase
      end
    end
  end

endmodule
